// File: rtl/ps2_kbd_rx.sv
// Receive-only PS/2 keyboard front end: synchronise and filter the bus, deframe
// 11-bit frames and fold E0/F0 prefixes into flags on each delivered scan code.
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_scan_code,
    output logic       rx_released,
    output logic       rx_extended,
    output logic       rx_scan_ready,
    input  logic       rx_scan_read,
    output logic       rx_err,
    output logic       rx_overrun
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0]    code_q, code_d;
    logic          rel_q, rel_d, ext_q, ext_d, rdy_q, rdy_d;
    logic          err_q, err_d, ovr_q, ovr_d;
    logic          fall;

    // The filtered clock only flips after FILTER_LEN straight disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        rel_d      = rel_q;
        ext_d      = ext_q;
        rdy_d      = rdy_q;
        err_d      = 1'b0;
        ovr_d      = 1'b0;
        tcnt_d     = (state_q == IDLE) ? '0 : tcnt_q + 1'b1;

        if (rdy_q && rx_scan_read) rdy_d = 1'b0;

        if (fall) begin
            tcnt_d = '0;
            case (state_q)
                IDLE: if (!dat_s2_q) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                            // A read in this same cycle frees the slot for the new code.
                            if (rdy_q && !rx_scan_read) begin
                                ovr_d = 1'b1;
                            end else begin
                                code_d = shift_q;
                                rel_d  = brk_pend_q;
                                ext_d  = ext_pend_q;
                                rdy_d  = 1'b1;
                            end
                        end
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT_CYC)) begin
            state_d    = IDLE;
            tcnt_d     = '0;
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bcnt_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= '0;
            rel_q      <= 1'b0;
            ext_q      <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data_i;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            rel_q      <= rel_d;
            ext_q      <= ext_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_scan_code  = code_q;
    assign rx_released   = rel_q;
    assign rx_extended   = ext_q;
    assign rx_scan_ready = rdy_q;
    assign rx_err        = err_q;
    assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_kbd_rx;
    localparam int FL = 8;
    localparam int TO = 200;
    localparam int H  = 20;   // clk cycles per PS/2 clock phase
    localparam int GL = 5;    // glitch width, below FL-1

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd_man = 1'b0;
    logic       tie = 1'b0;
    logic       rd;
    logic [7:0] code;
    logic       rel, ext, rdy, err, ovr;

    int n_chk = 0;
    int n_err = 0;
    int err_n = 0;
    int ovr_n = 0;
    int rdy_n = 0;
    int e0, o0, r0;

    always #5 clk = ~clk;

    assign rd = tie ? rdy : rd_man;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_dat),
        .rx_scan_code(code), .rx_released(rel), .rx_extended(ext),
        .rx_scan_ready(rdy), .rx_scan_read(rd), .rx_err(err), .rx_overrun(ovr)
    );

    always @(posedge clk) begin
        if (err) err_n <= err_n + 1;
        if (ovr) ovr_n <= ovr_n + 1;
        if (rdy) rdy_n <= rdy_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low phase.
    task automatic ps2_bit(input logic b, input logic glitch, input logic rd_at_fall);
        ps2_dat = b;
        if (glitch) begin
            cyc(12); ps2_clk = 1'b0; cyc(GL); ps2_clk = 1'b1; cyc(H - 12 - GL);
        end else begin
            cyc(H);
        end
        ps2_clk = 1'b0;
        if (rd_at_fall) begin
            // Read lands in the cycle the stop edge is recognised.
            cyc(FL + 1); rd_man = 1'b1; cyc(1); rd_man = 1'b0; cyc(H - FL - 2);
        end else if (glitch) begin
            cyc(12); ps2_clk = 1'b1; cyc(GL); ps2_clk = 1'b0; cyc(H - 12 - GL);
        end else begin
            cyc(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok,
                              input logic glitch, input logic rd_at_stop);
        ps2_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch, 1'b0);
        ps2_bit((~^b) ^ ~par_ok, glitch, 1'b0);
        ps2_bit(1'b1, glitch, rd_at_stop);
        cyc(H);
    endtask

    task automatic send_partial(input int n);
        logic [7:0] b;
        b = 8'hA5;
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i], 1'b0, 1'b0);
    endtask

    task automatic do_read();
        rd_man = 1'b1; cyc(1); rd_man = 1'b0; cyc(1);
    endtask

    initial begin
        cyc(3);
        chk("rst_code", code, 8'h00);
        chk("rst_flags", {rel, ext, rdy, err, ovr}, 5'b0);
        rst = 1'b0;
        cyc(5);
        e0 = err_n; o0 = ovr_n;

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("1c_code", code, 8'h1C);
        chk("1c_flags", {rel, ext, rdy}, 3'b001);
        cyc(30);
        chk("1c_held", rdy, 1'b1);
        do_read();
        chk("1c_rdclr", rdy, 1'b0);
        chk("1c_hold_code", code, 8'h1C);
        do_read();
        chk("idle_read_ign", {rdy, code}, {1'b0, 8'h1C});

        send_frame(8'hE0, 1'b1, 1'b0, 1'b0);
        chk("e0_noready", rdy, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        chk("f0_noready", rdy, 1'b0);
        send_frame(8'h75, 1'b1, 1'b0, 1'b0);
        chk("75_code", code, 8'h75);
        chk("75_flags", {rel, ext, rdy}, 3'b111);
        chk("prefix_noerr", err_n - e0, 0);
        do_read();

        e0 = err_n;
        send_frame(8'hE0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("badpar_err", err_n - e0, 1);
        chk("badpar_noready", rdy, 1'b0);
        send_frame(8'h32, 1'b1, 1'b0, 1'b0);
        chk("32_code", code, 8'h32);
        chk("32_flags", {rel, ext, rdy}, 3'b001);
        do_read();

        e0 = err_n;
        send_partial(4);
        cyc(TO + 50);
        chk("timeout_err", err_n - e0, 1);
        chk("timeout_noready", rdy, 1'b0);
        send_frame(8'h21, 1'b1, 1'b0, 1'b0);
        chk("21_code", code, 8'h21);
        chk("21_flags", {rel, ext, rdy}, 3'b001);
        chk("21_noerr", err_n - e0, 1);
        do_read();

        o0 = ovr_n;
        send_frame(8'h15, 1'b1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b1, 1'b0, 1'b0);
        chk("ovr_keep_code", code, 8'h15);
        chk("ovr_keep_flags", {rel, ext, rdy}, 3'b001);
        chk("ovr_pulse", ovr_n - o0, 1);
        do_read();
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        chk("ovr_pend_clr", {code, rel, ext, rdy}, {8'h33, 3'b001});
        do_read();

        send_frame(8'h15, 1'b1, 1'b0, 1'b0);
        o0 = ovr_n;
        send_frame(8'h1D, 1'b1, 1'b0, 1'b1);
        chk("simul_code", code, 8'h1D);
        chk("simul_ready", rdy, 1'b1);
        chk("simul_noovr", ovr_n - o0, 0);
        do_read();

        tie = 1'b1;
        r0 = rdy_n;
        send_frame(8'h2A, 1'b1, 1'b0, 1'b0);
        chk("tied_pulse", rdy_n - r0, 1);
        chk("tied_code", {code, rdy}, {8'h2A, 1'b0});
        tie = 1'b0;

        e0 = err_n;
        send_frame(8'h4B, 1'b1, 1'b1, 1'b0);
        chk("glitch_code", code, 8'h4B);
        chk("glitch_flags", {rel, ext, rdy}, 3'b001);
        chk("glitch_noerr", err_n - e0, 0);
        do_read();

        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        send_partial(3);
        rst = 1'b1;
        cyc(2);
        chk("midrst_out", {code, rel, ext, rdy, err, ovr}, 13'b0);
        e0 = err_n; o0 = ovr_n;
        rst = 1'b0;
        cyc(20);
        chk("rst_rel_nopulse", (err_n - e0) + (ovr_n - o0), 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("5a_code", code, 8'h5A);
        chk("5a_flags", {rel, ext, rdy}, 3'b001);
        chk("5a_noerr", err_n - e0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
